// File: rtl/pipe_adder_if.sv
// Handshake bundle for pipe_adder: operand beat in, result beat out.
// WIDTH must match the WIDTH of the pipe_adder instance it connects to.
interface pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Carry-chunked pipelined adder/subtractor: stage k adds chunk k with the carry from stage k-1.
// Define PIPE_ADDER_SAT_EN to saturate on unsigned carry-out (add) or borrow (sub).
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  bus
);
    localparam int CW = WIDTH / STAGES;

    typedef logic [WIDTH-1:0] word_t;

    // Per-stage registers; a_q/b_q carry the not-yet-added upper operand chunks,
    // s_q accumulates the finished lower result chunks.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    word_t             a_q [STAGES];
    word_t             b_q [STAGES];
    word_t             s_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] vld_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_d;
    word_t             a_in [STAGES];
    word_t             b_in [STAGES];
    word_t             s_in [STAGES];
    word_t             s_d  [STAGES];
    logic [CW:0]       chunk;
    logic              ovf_d;
    logic              adv;

`ifdef PIPE_ADDER_SAT_EN
    logic [STAGES-1:0] sub_q;
    logic [STAGES-1:0] sub_in;
`endif

    assign adv           = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_sum   = {c_q[STAGES-1], s_q[STAGES-1]};
    assign bus.out_ovf   = ovf_q;

    always_comb begin
        vld_in[0] = bus.in_valid;
        a_in[0]   = bus.in_a;
        b_in[0]   = bus.in_sub ? ~bus.in_b : bus.in_b;
        c_in[0]   = bus.in_sub | bus.in_cin;
        s_in[0]   = '0;
`ifdef PIPE_ADDER_SAT_EN
        sub_in[0] = bus.in_sub;
`endif
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            c_in[k]   = c_q[k-1];
            s_in[k]   = s_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
            sub_in[k] = sub_q[k-1];
`endif
        end

        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                  + {{CW{1'b0}}, c_in[k]};
            s_d[k]              = s_in[k];
            s_d[k][k*CW +: CW]  = chunk[CW-1:0];
            c_d[k]              = chunk[CW];
        end

        // Overflow is judged on the raw sum, before any saturation.
        ovf_d = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1])
             && (s_d[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);

`ifdef PIPE_ADDER_SAT_EN
        // Add with carry-out, or sub with borrow, clamps to the unsigned range.
        if (sub_in[STAGES-1] != c_d[STAGES-1]) begin
            s_d[STAGES-1] = sub_in[STAGES-1] ? '0 : '1;
            c_d[STAGES-1] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef PIPE_ADDER_SAT_EN
            sub_q <= '0;
`endif
        end else if (adv) begin
            vld_q <= vld_in;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
`ifdef PIPE_ADDER_SAT_EN
            sub_q <= sub_in;
`endif
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed vector table, stream/stall/reset sequences on an 8/2 instance,
// and a randomized scoreboard run on a 32/4 instance.
module tb_pipe_adder;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(8))  b8 ();
    pipe_adder_if #(.WIDTH(32)) b32 ();

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    typedef struct {
        longint sum;
        bit     ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] sum;
        logic       ovf;
    } vec_t;

    int errors = 0;
    int checks = 0;

    res_t   q8[$];
    res_t   q32[$];
    res_t   e8, e32;
    int     out8 = 0, acc8 = 0, out32 = 0, acc32 = 0;
    int     run8 = 0, max_run8 = 0;
    bit     prev_take8 = 0;
    bit     hold8_v = 0, hold32_v = 0;
    longint hold8_sum, hold32_sum;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub);
        res_t   r;
        longint m, half, sa, sb, sr, full;
        m    = longint'(1) << w;
        half = m >> 1;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub) begin
            full = a + m - b;
            sr   = sa - sb;
        end else begin
            full = a + b + longint'(cin);
            sr   = sa + sb + longint'(cin);
        end
        r.ovf = (sr >= half) || (sr < -half);
        if (SAT && !sub && full >= m) full = m - 1;
        if (SAT && sub && a < b) full = 0;
        r.sum = full;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            hold8_v    = 1'b0;
            prev_take8 = 1'b0;
        end else begin
            check("in_ready8_adv", longint'(b8.in_ready),
                  longint'(!b8.out_valid || b8.out_ready));
            if (hold8_v) begin
                check("hold8_valid", longint'(b8.out_valid), 1);
                check("hold8_sum", longint'(b8.out_sum), hold8_sum);
            end
            if (b8.out_valid && b8.out_ready) begin
                out8++;
                run8 = prev_take8 ? run8 + 1 : 1;
                if (run8 > max_run8) max_run8 = run8;
                prev_take8 = 1'b1;
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb8_extra: got output 0x%0h, expected none", b8.out_sum);
                end else begin
                    e8 = q8.pop_front();
                    check("sb8_sum", longint'(b8.out_sum), e8.sum);
                    check("sb8_ovf", longint'(b8.out_ovf), longint'(e8.ovf));
                end
            end else begin
                prev_take8 = 1'b0;
            end
            hold8_v   = b8.out_valid && !b8.out_ready;
            hold8_sum = longint'(b8.out_sum);
            if (b8.in_valid && b8.in_ready) begin
                acc8++;
                q8.push_back(model(8, longint'(b8.in_a), longint'(b8.in_b), b8.in_cin, b8.in_sub));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            hold32_v = 1'b0;
        end else begin
            if (hold32_v) begin
                check("hold32_valid", longint'(b32.out_valid), 1);
                check("hold32_sum", longint'(b32.out_sum), hold32_sum);
            end
            if (b32.out_valid && b32.out_ready) begin
                out32++;
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb32_extra: got output 0x%0h, expected none", b32.out_sum);
                end else begin
                    e32 = q32.pop_front();
                    check("sb32_sum", longint'(b32.out_sum), e32.sum);
                    check("sb32_ovf", longint'(b32.out_ovf), longint'(e32.ovf));
                end
            end
            hold32_v   = b32.out_valid && !b32.out_ready;
            hold32_sum = longint'(b32.out_sum);
            if (b32.in_valid && b32.in_ready) begin
                acc32++;
                q32.push_back(model(32, longint'(b32.in_a), longint'(b32.in_b),
                                    b32.in_cin, b32.in_sub));
            end
        end
    end

    initial begin
        vec_t vec[10];
        bit   pat[4];
        int   o0, a0;

        vec[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, SAT ? 9'h0FF : 9'h100, 1'b0};
        vec[1] = '{8'h05, 8'h07, 1'b0, 1'b1, SAT ? 9'h000 : 9'h0FE, 1'b0};
        vec[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 9'h17F, 1'b1};
        vec[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1};
        vec[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 9'h080, 1'b1};
        vec[5] = '{8'h10, 8'h20, 1'b1, 1'b1, SAT ? 9'h000 : 9'h0F0, 1'b0};
        vec[6] = '{8'h80, 8'h80, 1'b0, 1'b0, SAT ? 9'h0FF : 9'h100, 1'b1};
        vec[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 9'h100, 1'b0};
        vec[8] = '{8'h3C, 8'hC4, 1'b0, 1'b0, SAT ? 9'h0FF : 9'h100, 1'b0};
        vec[9] = '{8'h12, 8'h34, 1'b1, 1'b0, 9'h047, 1'b0};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        {b8.in_valid, b8.in_a, b8.in_b, b8.in_cin, b8.in_sub, b8.out_ready} = '0;
        {b32.in_valid, b32.in_a, b32.in_b, b32.in_cin, b32.in_sub, b32.out_ready} = '0;
        #2;
        check("rst_out_valid", longint'(b8.out_valid), 0);
        check("rst_out_sum", longint'(b8.out_sum), 0);
        check("rst_out_ovf", longint'(b8.out_ovf), 0);
        check("rst_in_ready", longint'(b8.in_ready), 1);
        check("rst_out_valid32", longint'(b32.out_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors: exact 2-cycle latency and result per record.
        b8.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b8.in_a     = vec[i].a;
            b8.in_b     = vec[i].b;
            b8.in_cin   = vec[i].cin;
            b8.in_sub   = vec[i].sub;
            b8.in_valid = 1'b1;
            check($sformatf("v%0d_in_ready", i), longint'(b8.in_ready), 1);
            @(posedge clk);
            #1 b8.in_valid = 1'b0;
            check($sformatf("v%0d_lat1_valid", i), longint'(b8.out_valid), 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_lat2_valid", i), longint'(b8.out_valid), 1);
            check($sformatf("v%0d_sum", i), longint'(b8.out_sum), longint'(vec[i].sum));
            check($sformatf("v%0d_ovf", i), longint'(b8.out_ovf), longint'(vec[i].ovf));
            @(posedge clk);
            #1;
        end

        // Ten back-to-back beats must emerge on ten consecutive cycles.
        o0 = out8;
        max_run8 = 0;
        for (int i = 0; i < 10; i++) begin
            b8.in_valid = 1'b1;
            b8.in_a     = 8'($urandom());
            b8.in_b     = 8'($urandom());
            b8.in_cin   = 1'($urandom());
            b8.in_sub   = 1'($urandom());
            @(posedge clk);
            #1;
        end
        b8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stream_count", longint'(out8 - o0), 10);
        check("stream_consecutive", longint'(max_run8), 10);

        // Streaming with out_ready pattern 1,0,0,1.
        o0 = out8;
        a0 = acc8;
        for (int i = 0; i < 16; i++) begin
            b8.in_valid  = 1'b1;
            b8.in_a      = 8'($urandom());
            b8.in_b      = 8'($urandom());
            b8.in_cin    = 1'($urandom());
            b8.in_sub    = 1'($urandom());
            b8.out_ready = pat[i%4];
            @(posedge clk);
            #1;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        for (int t = 0; t < 20 && q8.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("stall_drained", longint'(q8.size()), 0);
        check("stall_in_out_equal", longint'(out8 - o0), longint'(acc8 - a0));

        // Reset with two beats in flight.
        b8.out_ready = 1'b0;
        b8.in_valid  = 1'b1;
        b8.in_a      = 8'h01;
        b8.in_b      = 8'h02;
        b8.in_cin    = 1'b0;
        b8.in_sub    = 1'b0;
        @(posedge clk);
        #1 b8.in_a = 8'h03;
        b8.in_b = 8'h04;
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        check("pre_rst_valid", longint'(b8.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(b8.out_valid), 0);
        check("midrst_out_sum", longint'(b8.out_sum), 0);
        check("midrst_out_ovf", longint'(b8.out_ovf), 0);
        check("midrst_in_ready", longint'(b8.in_ready), 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_idle", longint'(b8.out_valid), 0);
        o0 = out8;
        b8.out_ready = 1'b1;
        b8.in_a      = 8'h10;
        b8.in_b      = 8'h20;
        b8.in_valid  = 1'b1;
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_valid", longint'(b8.out_valid), 1);
        check("postrst_sum", longint'(b8.out_sum), 'h030);
        repeat (4) @(posedge clk);
        #1;
        check("postrst_only_one", longint'(out8 - o0), 1);

        // Random 32/4 run with random stalls.
        while (acc32 < 10000 && out32 < 10000 + 1) begin
            b32.in_valid  = ($urandom_range(0, 3) != 0);
            b32.in_a      = $urandom();
            b32.in_b      = $urandom();
            b32.in_cin    = 1'($urandom());
            b32.in_sub    = 1'($urandom());
            b32.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            if ($time > 64'd900000) break;
        end
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        for (int t = 0; t < 50 && q32.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("rand_accepted", longint'(acc32), 10000);
        check("rand_drained", longint'(q32.size()), 0);
        check("rand_outputs", longint'(out32), 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
